// File: rtl/fsm_seq_pkg.sv
// Shared types and code constants for the sequence-detector stimulus generator.
// The detector walks IDLE -> S1 -> S2 -> DONE; these codes steer it along each path.
package fsm_seq_pkg;

    typedef enum logic [1:0] {
        CMD_ILLEGAL = 2'd0,
        CMD_DIRECT  = 2'd1,
        CMD_VIA2    = 2'd2,
        CMD_LOOP    = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        ST_DONE = 2'd0,
        ST_S1   = 2'd1,
        ST_S2   = 2'd2,
        ST_IDLE = 2'd3
    } det_status_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISMATCH = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_ILLEGAL  = 2'd3
    } err_t;

    // Generator FSM states; prefixed FSM_ so they never collide with the detector status names.
    typedef enum logic [2:0] {
        FSM_IDLE,
        FSM_DRIVE,
        FSM_GAP,
        FSM_WAIT,
        FSM_REPORT
    } fsm_state_t;

    localparam logic [3:0] CODE_ENTER   = 4'd14;
    localparam logic [3:0] CODE_TO_S2   = 4'd10;
    localparam logic [3:0] CODE_S2_DONE = 4'd7;
    localparam logic [3:0] CODE_S1_DONE = 4'd3;
    localparam logic [3:0] CODE_BACK    = 4'd1;
    localparam logic [3:0] IDLE_CODE    = 4'd0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/fsm_seq_rom.sv
// Path table: maps (command, step) to the code to drive, the detector status
// expected after it, and whether this step finishes the path.
module fsm_seq_rom
    import fsm_seq_pkg::*;
(
    input  cmd_t        cmd,
    input  logic [1:0]  step,
    output logic [3:0]  code,
    output det_status_t expected,
    output logic        is_final
);

    always_comb begin
        code     = IDLE_CODE;
        expected = ST_IDLE;
        is_final = 1'b1;
        case (cmd)
            CMD_DIRECT: begin
                case (step)
                    2'd0: begin code = CODE_ENTER; expected = ST_S1; is_final = 1'b0; end
                    default: begin code = CODE_S1_DONE; expected = ST_DONE; end
                endcase
            end
            CMD_VIA2: begin
                case (step)
                    2'd0: begin code = CODE_ENTER; expected = ST_S1; is_final = 1'b0; end
                    2'd1: begin code = CODE_TO_S2; expected = ST_S2; is_final = 1'b0; end
                    default: begin code = CODE_S2_DONE; expected = ST_DONE; end
                endcase
            end
            CMD_LOOP: begin
                case (step)
                    2'd0: begin code = CODE_ENTER; expected = ST_S1; is_final = 1'b0; end
                    2'd1: begin code = CODE_TO_S2; expected = ST_S2; is_final = 1'b0; end
                    2'd2: begin code = CODE_BACK;  expected = ST_S1; is_final = 1'b0; end
                    default: begin code = CODE_S1_DONE; expected = ST_DONE; end
                endcase
            end
            default: begin
                code     = IDLE_CODE;
                expected = ST_IDLE;
                is_final = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fsm_seq_gen.sv
// Drives a code sequence onto the detector bus for each accepted command, checks the
// detector status after every code and reports done or a coded error as a one-cycle pulse.
module fsm_seq_gen
    import fsm_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 1,
    parameter int GAP_CYCLES  = 1,
    parameter int TIMEOUT     = 15,
    parameter int CNT_W       = $clog2(max3(HOLD_CYCLES, GAP_CYCLES, TIMEOUT) + 1)
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cmd_valid,
    input  logic [1:0] i_cmd,
    output logic       o_cmd_ready,
    output logic [3:0] o_bus,
    input  logic [1:0] i_status,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [1:0] o_err_code
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);

    fsm_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       step_reg, step_next;
    cmd_t             cmd_reg, cmd_next;
    logic             done_seen_reg, done_seen_next;
    logic [3:0]       bus_reg, bus_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;
    err_t             err_code_reg, err_code_next;

    det_status_t      status;
    logic [3:0]       cur_code, nxt_code;
    det_status_t      cur_expected, nxt_expected;
    logic             cur_final, nxt_final;
    logic             rom_unused;

    assign status = det_status_t'(i_status);

    // One lookup checks the step in progress; the other supplies the code registered onto o_bus.
    fsm_seq_rom u_rom_cur (
        .cmd      (cmd_reg),
        .step     (step_reg),
        .code     (cur_code),
        .expected (cur_expected),
        .is_final (cur_final)
    );

    fsm_seq_rom u_rom_nxt (
        .cmd      (cmd_next),
        .step     (step_next),
        .code     (nxt_code),
        .expected (nxt_expected),
        .is_final (nxt_final)
    );

    assign rom_unused = ^{cur_code, nxt_expected, nxt_final};

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        step_next      = step_reg;
        cmd_next       = cmd_reg;
        done_seen_next = done_seen_reg;
        done_next      = 1'b0;
        err_next       = 1'b0;
        err_code_next  = ERR_NONE;

        // DONE lasts a single cycle, so latch it anywhere from the final code onward.
        if ((((state_reg == FSM_DRIVE) || (state_reg == FSM_GAP)) && cur_final) ||
            (state_reg == FSM_WAIT)) begin
            if (status == ST_DONE) done_seen_next = 1'b1;
        end

        case (state_reg)
            FSM_IDLE: begin
                if (i_cmd_valid) begin
                    cmd_next       = cmd_t'(i_cmd);
                    step_next      = 2'd0;
                    cnt_next       = '0;
                    done_seen_next = 1'b0;
                    if (cmd_t'(i_cmd) == CMD_ILLEGAL) begin
                        state_next    = FSM_REPORT;
                        err_next      = 1'b1;
                        err_code_next = ERR_ILLEGAL;
                    end else begin
                        state_next = FSM_DRIVE;
                    end
                end
            end
            FSM_DRIVE: begin
                if (cnt_reg == HOLD_LAST) begin
                    cnt_next   = '0;
                    state_next = FSM_GAP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            FSM_GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    cnt_next = '0;
                    if (cur_final) begin
                        state_next = FSM_WAIT;
                    end else if (status == cur_expected) begin
                        step_next  = step_reg + 2'd1;
                        state_next = FSM_DRIVE;
                    end else begin
                        state_next    = FSM_REPORT;
                        err_next      = 1'b1;
                        err_code_next = ERR_MISMATCH;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            FSM_WAIT: begin
                if (done_seen_reg && (status == ST_IDLE)) begin
                    state_next = FSM_REPORT;
                    done_next  = 1'b1;
                end else if (cnt_reg == TO_LAST) begin
                    state_next    = FSM_REPORT;
                    err_next      = 1'b1;
                    err_code_next = ERR_TIMEOUT;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            FSM_REPORT: begin
                state_next = FSM_IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = FSM_IDLE;
                cnt_next   = '0;
            end
        endcase

        bus_next = (state_next == FSM_DRIVE) ? nxt_code : IDLE_CODE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= FSM_IDLE;
            cnt_reg       <= '0;
            step_reg      <= 2'd0;
            cmd_reg       <= CMD_ILLEGAL;
            done_seen_reg <= 1'b0;
            bus_reg       <= IDLE_CODE;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            err_code_reg  <= ERR_NONE;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            step_reg      <= step_next;
            cmd_reg       <= cmd_next;
            done_seen_reg <= done_seen_next;
            bus_reg       <= bus_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            err_code_reg  <= err_code_next;
        end
    end

    assign o_bus       = bus_reg;
    assign o_done      = done_reg;
    assign o_err       = err_reg;
    assign o_err_code  = err_code_reg;
    assign o_cmd_ready = (state_reg == FSM_IDLE);
    assign o_busy      = (state_reg != FSM_IDLE);

endmodule

// File: tb/tb_fsm_seq_gen.sv
// Bench for fsm_seq_gen: two instances (H=G=1 and H=G=2) each wired to a behavioural
// detector; expected bus traces and outcomes come from the path table and timing rules.
module tb_fsm_seq_gen;

    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic       sel = 1'b0;
    logic       valid_drv = 1'b0;
    logic [1:0] cmd_drv = 2'd0;
    int         det_mode = 0;
    logic       det_clr = 1'b0;

    logic       valid_a, ready_a, busy_a, done_a, err_a;
    logic [3:0] bus_a;
    logic [1:0] status_a, err_code_a;
    logic       valid_b, ready_b, busy_b, done_b, err_b;
    logic [3:0] bus_b;
    logic [1:0] status_b, err_code_b;

    logic       m_ready, m_busy, m_done, m_err;
    logic [3:0] m_bus;
    logic [1:0] m_err_code, m_status;

    int exp_bus[$];

    assign valid_a = valid_drv & ~sel;
    assign valid_b = valid_drv & sel;

    always_comb begin
        m_ready    = sel ? ready_b : ready_a;
        m_busy     = sel ? busy_b : busy_a;
        m_done     = sel ? done_b : done_a;
        m_err      = sel ? err_b : err_a;
        m_bus      = sel ? bus_b : bus_a;
        m_err_code = sel ? err_code_b : err_code_a;
        m_status   = sel ? status_b : status_a;
    end

    fsm_seq_gen #(.HOLD_CYCLES(1), .GAP_CYCLES(1), .TIMEOUT(TIMEOUT)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(valid_a), .i_cmd(cmd_drv),
        .o_cmd_ready(ready_a), .o_bus(bus_a), .i_status(status_a), .o_busy(busy_a),
        .o_done(done_a), .o_err(err_a), .o_err_code(err_code_a)
    );

    fsm_seq_gen #(.HOLD_CYCLES(2), .GAP_CYCLES(2), .TIMEOUT(TIMEOUT)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(valid_b), .i_cmd(cmd_drv),
        .o_cmd_ready(ready_b), .o_bus(bus_b), .i_status(status_b), .o_busy(busy_b),
        .o_done(done_b), .o_err(err_b), .o_err_code(err_code_b)
    );

    // Detector behaviour. mode 0 normal, 1 stuck at IDLE, 2 never reports DONE (holds),
    // 3 jumps straight to IDLE instead of DONE.
    function automatic logic [1:0] det_next(input logic [1:0] s, input logic [3:0] c, input int mode);
        logic [1:0] fin;
        fin = (mode == 2) ? s : ((mode == 3) ? 2'd3 : 2'd0);
        if (mode == 1) return 2'd3;
        case (s)
            2'd0: return 2'd3;
            2'd1: begin
                if (c == 4'd10) return 2'd2;
                if (c == 4'd3) return fin;
                return 2'd1;
            end
            2'd2: begin
                if (c == 4'd7) return fin;
                if (c == 4'd1) return 2'd1;
                return 2'd2;
            end
            default: return (c == 4'd14) ? 2'd1 : 2'd3;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) status_a <= 2'd3;
        else if (det_clr) status_a <= 2'd3;
        else status_a <= det_next(status_a, bus_a, det_mode);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) status_b <= 2'd3;
        else if (det_clr) status_b <= 2'd3;
        else status_b <= det_next(status_b, bus_b, det_mode);
    end

    function automatic int path_code(input int cmd, input int idx);
        int direct_p[2] = '{14, 3};
        int via2_p[3]   = '{14, 10, 7};
        int loop_p[4]   = '{14, 10, 1, 3};
        case (cmd)
            1: return direct_p[idx];
            2: return via2_p[idx];
            default: return loop_p[idx];
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle bus trace for T+1..T+lat, and outcome at T+lat (kind 1 done, 2 err).
    task automatic build_expect(input int cmd, input int mode, output int lat, output int kind, output int ecode);
        int h, g, n;
        h = sel ? 2 : 1;
        g = h;
        exp_bus.delete();
        if (cmd == 0) begin
            lat = 1; kind = 2; ecode = 3;
        end else if (mode == 1) begin
            repeat (h) exp_bus.push_back(14);
            lat = h + g + 1; kind = 2; ecode = 1;
        end else begin
            n = cmd + 1;
            for (int s = 0; s < n; s++) begin
                repeat (h) exp_bus.push_back(path_code(cmd, s));
                repeat (g) exp_bus.push_back(0);
            end
            if (mode == 0) begin
                lat = n * (h + g) + 2; kind = 1; ecode = 0;
            end else begin
                lat = n * (h + g) + 1 + TIMEOUT; kind = 2; ecode = 2;
            end
        end
        while (exp_bus.size() < lat) exp_bus.push_back(0);
    endtask

    // Called at the T+1 sample point of an accepted command.
    task automatic check_sequence(input int cmd, input int mode, input string name);
        int lat, kind, ecode;
        logic [4:0] exp_flags;
        logic [3:0] exp_b;
        build_expect(cmd, mode, lat, kind, ecode);
        for (int k = 1; k <= lat; k++) begin
            exp_b = 4'(exp_bus[k-1]);
            vectors++;
            if (m_bus !== exp_b) begin
                miscompares++;
                $display("FAIL %s bus at T+%0d: got %0d want %0d", name, k, m_bus, exp_b);
            end
            exp_flags = {1'b1, (k == lat && kind == 1), (k == lat && kind == 2),
                         (k == lat) ? 2'(ecode) : 2'd0};
            vectors++;
            if ({m_busy, m_done, m_err, m_err_code} !== exp_flags) begin
                miscompares++;
                $display("FAIL %s busy/done/err/code at T+%0d: got %b want %b", name, k,
                         {m_busy, m_done, m_err, m_err_code}, exp_flags);
            end
            tick();
        end
        vectors++;
        if ({m_ready, m_busy, m_done, m_err, m_bus} !== {4'b1000, 4'd0}) begin
            miscompares++;
            $display("FAIL %s after report: got ready/busy/done/err/bus %b want 1000_0000", name,
                     {m_ready, m_busy, m_done, m_err, m_bus});
        end
        $display("txn %s inst=%0d cmd=%0d mode=%0d latency=%0d", name, sel, cmd, mode, lat);
    endtask

    task automatic run_cmd(input logic s, input int cmd, input int mode, input string name);
        sel = s;
        det_mode = mode;
        det_clr = 1'b1;
        tick();
        det_clr = 1'b0;
        vectors++;
        if (m_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s ready before accept: got %b want 1", name, m_ready);
        end
        cmd_drv = 2'(cmd);
        valid_drv = 1'b1;
        tick();
        valid_drv = 1'b0;
        check_sequence(cmd, mode, name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid_drv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({ready_a, busy_a, done_a, err_a, err_code_a, bus_a, ready_b, busy_b, done_b, err_b, err_code_b, bus_b}
            !== {6'b100000, 4'd0, 6'b100000, 4'd0}) begin
            miscompares++;
            $display("FAIL reset_hold outputs: got %b %b want 100000_0000 x2",
                     {ready_a, busy_a, done_a, err_a, err_code_a, bus_a},
                     {ready_b, busy_b, done_b, err_b, err_code_b, bus_b});
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if ({ready_a, busy_a, done_a, err_a, err_code_a, bus_a} !== {6'b100000, 4'd0}) begin
            miscompares++;
            $display("FAIL reset_release outputs: got %b want 100000_0000",
                     {ready_a, busy_a, done_a, err_a, err_code_a, bus_a});
        end
    endtask

    task automatic test_loop_h2();
        run_cmd(1'b1, 3, 0, "loop_h2");
        vectors++;
        if (status_b !== 2'd3) begin
            miscompares++;
            $display("FAIL loop_h2 detector end state: got %0d want 3", status_b);
        end
    endtask

    task automatic test_busy_ignore();
        int k, done_k;
        sel = 1'b0;
        det_mode = 0;
        det_clr = 1'b1;
        tick();
        det_clr = 1'b0;
        cmd_drv = 2'd1;
        valid_drv = 1'b1;
        tick();
        valid_drv = 1'b0;
        tick();
        cmd_drv = 2'd2;
        valid_drv = 1'b1;
        k = 2;
        done_k = -1;
        while (m_ready !== 1'b1 && k < 40) begin
            if (m_done === 1'b1) done_k = k;
            tick();
            k++;
        end
        vectors++;
        if (k != 7 || done_k != 6) begin
            miscompares++;
            $display("FAIL busy_ignore ready/done cycle: got ready T+%0d done T+%0d want T+7 T+6", k, done_k);
        end
        tick();
        valid_drv = 1'b0;
        check_sequence(2, 0, "held_via2");
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        det_mode = 0;
        det_clr = 1'b1;
        tick();
        det_clr = 1'b0;
        cmd_drv = 2'd2;
        valid_drv = 1'b1;
        tick();
        valid_drv = 1'b0;
        tick();
        tick();
        vectors++;
        if (bus_a !== 4'd10) begin
            miscompares++;
            $display("FAIL reset_mid bus before reset: got %0d want 10", bus_a);
        end
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if ({ready_a, busy_a, bus_a} !== {2'b10, 4'd0}) begin
            miscompares++;
            $display("FAIL reset_mid async clear: got ready/busy/bus %b want 10_0000", {ready_a, busy_a, bus_a});
        end
        #2 rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            vectors++;
            if ({ready_a, busy_a, done_a, err_a, bus_a} !== {4'b1000, 4'd0}) begin
                miscompares++;
                $display("FAIL reset_mid after release cycle %0d: got %b want 1000_0000", c,
                         {ready_a, busy_a, done_a, err_a, bus_a});
            end
        end
    endtask

    task automatic test_random();
        logic s;
        int c, m;
        for (int i = 0; i < 12; i++) begin
            s = 1'($urandom_range(0, 1));
            c = int'($urandom_range(0, 3));
            m = int'($urandom_range(0, 3));
            run_cmd(s, c, m, "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        test_reset();
        run_cmd(1'b0, 1, 0, "direct");
        test_loop_h2();
        run_cmd(1'b0, 2, 1, "via2_mismatch");
        run_cmd(1'b0, 1, 2, "timeout_no_done");
        run_cmd(1'b0, 1, 3, "timeout_idle_without_done");
        run_cmd(1'b0, 0, 0, "illegal");
        run_cmd(1'b1, 2, 1, "mismatch_h2");
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
